cfu_pipelined_credit_adapter: RTL and testbench

- Full-handshake CFU built around an internal LATENCY-stage function pipeline and an in-order response FIFO.
- Credit-based flow control: `req_ready` never depends combinationally on `resp_ready`, and the pipeline never stalls. A full response path throttles new requests instead.
- Successor to the stall-the-pipeline adapter: adds parametrised depth and latency, a multi-function datapath, and interface/function-ID error responses.
- Sits between a CPU CFU port and custom-function logic.

---
 rtl/cfu_pipelined_credit_adapter.sv | 189 ++++++++++++++++++
 tb/tb_cfu_pipelined_credit_adapter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_pipelined_credit_adapter.sv
// cfu_pipelined_credit_adapter
//   Credit-throttled CFU front end. Requests enter a fixed LATENCY-stage
//   function pipeline that never stalls. Results land in an in-order,
//   show-ahead response FIFO. The FIFO_DEPTH credits bound everything in the
//   pipeline plus the FIFO, so the last stage can always write.
//
//   Functions: 0 a*b (low bits), 1 a+b, 2 a-b, 3 a^b.
//   Errors:    1 = wrong interface ID, 2 = unknown function (interface wins).
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   clock_en_i          global enable; 0 freezes all state and handshakes
//   req_*_i / req_ready_o  request channel (req_data_i = {b, a})
//   resp_*_o / resp_ready_i  response channel (head of the FIFO)
//   credits_o           free credits (FIFO_DEPTH - outstanding)
//   stat_*_o            saturating counters, only with CFU_CREDIT_ADAPTER_STATS_EN
module cfu_pipelined_credit_adapter #(
    parameter int unsigned IID            = 16'h0001,
    parameter int unsigned INTERFACE_ID_W = 16,
    parameter int unsigned FUNCTION_ID_W  = 16,
    parameter int unsigned REQ_RESP_ID_W  = 6,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ERROR_ID_W     = 32,
    parameter int unsigned LATENCY        = 3,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              clock_en_i,
    output logic                              req_ready_o,
    input  logic                              req_valid_i,
    input  logic [INTERFACE_ID_W-1:0]         req_interface_id_i,
    input  logic [FUNCTION_ID_W-1:0]          req_function_id_i,
    input  logic [REQ_RESP_ID_W-1:0]          req_id_i,
    input  logic [2*DATA_W-1:0]               req_data_i,
    input  logic                              resp_ready_i,
    output logic                              resp_valid_o,
    output logic [REQ_RESP_ID_W-1:0]          resp_id_o,
    output logic [DATA_W-1:0]                 resp_data_o,
    output logic                              resp_ok_o,
    output logic [ERROR_ID_W-1:0]             resp_error_id_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   credits_o
`ifdef CFU_CREDIT_ADAPTER_STATS_EN
    ,
    output logic [31:0]                       stat_req_count_o,
    output logic [31:0]                       stat_err_count_o,
    output logic [31:0]                       stat_stall_cycles_o,
    output logic [31:0]                       stat_backpressure_cycles_o
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [REQ_RESP_ID_W-1:0] id;
        logic [DATA_W-1:0]        data;
        logic                     ok;
        logic [ERROR_ID_W-1:0]    err;
    } rsp_t;

    logic                  accept, pop, fifo_wr, fifo_full;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [LATENCY-1:0]    vld_pipe_q;
    rsp_t [LATENCY-1:0]    pipe_q;
    rsp_t                  s0_d;
    rsp_t [FIFO_DEPTH-1:0] mem_q;
    rsp_t                  head;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     op_a, op_b;

    // Credit state: req_ready comes from registers only, so a pop frees its
    // credit for the following cycle.
    assign req_ready_o = (outstanding_q != CNT_W'(FIFO_DEPTH));
    assign credits_o   = CNT_W'(FIFO_DEPTH) - outstanding_q;
    assign accept      = req_valid_i && req_ready_o && clock_en_i;
    assign pop         = resp_valid_o && resp_ready_i && clock_en_i;

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !pop)      outstanding_d = outstanding_q + CNT_W'(1);
        else if (pop && !accept) outstanding_d = outstanding_q - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)           outstanding_q <= '0;
        else if (clock_en_i) outstanding_q <= outstanding_d;
    end

    // Stage 0: decode, execute and resolve errors in one go.
    assign op_a = req_data_i[DATA_W-1:0];
    assign op_b = req_data_i[2*DATA_W-1:DATA_W];

    always_comb begin
        s0_d    = '0;
        s0_d.id = req_id_i;
        if (req_interface_id_i != INTERFACE_ID_W'(IID)) begin
            s0_d.err = ERROR_ID_W'(1);
        end else if (req_function_id_i > FUNCTION_ID_W'(3)) begin
            s0_d.err = ERROR_ID_W'(2);
        end else begin
            s0_d.ok = 1'b1;
            case (req_function_id_i[1:0])
                2'd0:    s0_d.data = op_a * op_b;
                2'd1:    s0_d.data = op_a + op_b;
                2'd2:    s0_d.data = op_a - op_b;
                default: s0_d.data = op_a ^ op_b;
            endcase
        end
    end

    // Free-running pipeline; only the valid bits need reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe_q <= '0;
        end else if (clock_en_i) begin
            vld_pipe_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (clock_en_i) begin
            pipe_q[0] <= s0_d;
            for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Response FIFO, show-ahead, arbitrary depth (pointers wrap explicitly).
    function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_wr   = clock_en_i && vld_pipe_q[LATENCY-1];
    assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clock_en_i) begin
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= pipe_q[LATENCY-1];
                wr_ptr_q        <= ptr_nxt(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_nxt(rd_ptr_q);
            case ({fifo_wr, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Credits make a write into a full, non-draining FIFO unreachable.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(fifo_wr && fifo_full && !pop));

    // Fields read as zero while empty so reset state is all-zero.
    assign head            = mem_q[rd_ptr_q];
    assign resp_valid_o    = (cnt_q != '0);
    assign resp_id_o       = resp_valid_o ? head.id   : '0;
    assign resp_data_o     = resp_valid_o ? head.data : '0;
    assign resp_ok_o       = resp_valid_o ? head.ok   : 1'b0;
    assign resp_error_id_o = resp_valid_o ? head.err  : '0;

`ifdef CFU_CREDIT_ADAPTER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_req_count_o           <= '0;
            stat_err_count_o           <= '0;
            stat_stall_cycles_o        <= '0;
            stat_backpressure_cycles_o <= '0;
        end else if (clock_en_i) begin
            if (accept && stat_req_count_o != '1)
                stat_req_count_o <= stat_req_count_o + 32'd1;
            if (accept && !s0_d.ok && stat_err_count_o != '1)
                stat_err_count_o <= stat_err_count_o + 32'd1;
            if (req_valid_i && !req_ready_o && stat_stall_cycles_o != '1)
                stat_stall_cycles_o <= stat_stall_cycles_o + 32'd1;
            if (resp_valid_o && !resp_ready_i && stat_backpressure_cycles_o != '1)
                stat_backpressure_cycles_o <= stat_backpressure_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cfu_pipelined_credit_adapter.sv
module tb_cfu_pipelined_credit_adapter;

    logic        clock, reset, clock_en_i;
    logic        req_ready_o, req_valid_i;
    logic [15:0] req_interface_id_i, req_function_id_i;
    logic [5:0]  req_id_i;
    logic [63:0] req_data_i;
    logic        resp_ready_i, resp_valid_o, resp_ok_o;
    logic [5:0]  resp_id_o;
    logic [31:0] resp_data_o, resp_error_id_o;
    logic [2:0]  credits_o;
`ifdef CFU_CREDIT_ADAPTER_STATS_EN
    logic [31:0] stat_req_count_o, stat_err_count_o, stat_stall_cycles_o, stat_backpressure_cycles_o;
`endif

    int total = 0;
    int bad   = 0;

    cfu_pipelined_credit_adapter dut (
        .clock(clock), .reset(reset), .clock_en_i(clock_en_i),
        .req_ready_o(req_ready_o), .req_valid_i(req_valid_i),
        .req_interface_id_i(req_interface_id_i), .req_function_id_i(req_function_id_i),
        .req_id_i(req_id_i), .req_data_i(req_data_i),
        .resp_ready_i(resp_ready_i), .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o),
        .resp_data_o(resp_data_o), .resp_ok_o(resp_ok_o), .resp_error_id_o(resp_error_id_o),
        .credits_o(credits_o)
`ifdef CFU_CREDIT_ADAPTER_STATS_EN
        , .stat_req_count_o(stat_req_count_o), .stat_err_count_o(stat_err_count_o),
        .stat_stall_cycles_o(stat_stall_cycles_o),
        .stat_backpressure_cycles_o(stat_backpressure_cycles_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [15:0] iid, input logic [15:0] fn,
                           input logic [5:0] id, input logic [31:0] a, input logic [31:0] b);
        req_valid_i        = v;
        req_interface_id_i = iid;
        req_function_id_i  = fn;
        req_id_i           = id;
        req_data_i         = {b, a};
    endtask

    task automatic issue(input logic [15:0] iid, input logic [15:0] fn,
                         input logic [5:0] id, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        set_req(1'b1, iid, fn, id, a, b);
        while (!req_ready_o && n < 20) begin tick(); n++; end
        chk("issue_ready", {63'd0, req_ready_o}, 64'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [5:0] id, input logic [31:0] data,
                               input logic ok, input logic [31:0] err);
        int n = 0;
        while (!resp_valid_o && n < 20) begin tick(); n++; end
        chk({tag, "_valid"}, {63'd0, resp_valid_o}, 64'd1);
        chk({tag, "_id"},    {58'd0, resp_id_o}, {58'd0, id});
        chk({tag, "_data"},  {32'd0, resp_data_o}, {32'd0, data});
        chk({tag, "_ok"},    {63'd0, resp_ok_o}, {63'd0, ok});
        chk({tag, "_err"},   {32'd0, resp_error_id_o}, {32'd0, err});
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, nresp, acc3, c, nacc, stale;
        logic acc;

        reset = 1'b1; clock_en_i = 1'b1; resp_ready_i = 1'b0;
        set_req(1'b0, 16'd1, 16'd0, 6'd0, 32'd0, 32'd0);
        tick(); tick();
        reset = 1'b0;
        chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
        chk("rst_resp_id", {58'd0, resp_id_o}, 64'd0);
        chk("rst_resp_data", {32'd0, resp_data_o}, 64'd0);
        chk("rst_resp_ok", {63'd0, resp_ok_o}, 64'd0);
        chk("rst_resp_err", {32'd0, resp_error_id_o}, 64'd0);
        chk("rst_credits", {61'd0, credits_o}, 64'd4);

        // Single multiply: exact latency of 3 edges after acceptance.
        resp_ready_i = 1'b1;
        set_req(1'b1, 16'd1, 16'd0, 6'd5, 32'd7, 32'd6);
        tick();
        req_valid_i = 1'b0;
        chk("mul_credits_taken", {61'd0, credits_o}, 64'd3);
        chk("mul_lat0", {63'd0, resp_valid_o}, 64'd0);
        for (int k = 1; k < 3; k++) begin
            tick();
            chk("mul_lat_early", {63'd0, resp_valid_o}, 64'd0);
        end
        tick();
        chk("mul_valid", {63'd0, resp_valid_o}, 64'd1);
        chk("mul_data", {32'd0, resp_data_o}, 64'd42);
        chk("mul_id", {58'd0, resp_id_o}, 64'd5);
        chk("mul_ok", {63'd0, resp_ok_o}, 64'd1);
        chk("mul_err", {32'd0, resp_error_id_o}, 64'd0);
        tick();
        chk("mul_popped", {63'd0, resp_valid_o}, 64'd0);
        chk("mul_credits_back", {61'd0, credits_o}, 64'd4);

        // Add stream ids 0..9. A popped credit returns one cycle later, so the
        // first four accepts are back-to-back; ordering and data are exact.
        i = 0; nresp = 0; acc3 = 0; c = 0;
        set_req(1'b1, 16'd1, 16'd1, 6'd0, 32'd0, 32'd100);
        while (nresp < 10 && c < 80) begin
            acc = req_valid_i && req_ready_o;
            tick(); c++;
            if (acc) begin
                if (i == 3) acc3 = c;
                i++;
            end
            if (i < 10) set_req(1'b1, 16'd1, 16'd1, 6'(i), 32'(i), 32'd100);
            else        req_valid_i = 1'b0;
            if (resp_valid_o) begin
                chk("stream_id", {58'd0, resp_id_o}, 64'(nresp));
                chk("stream_data", {32'd0, resp_data_o}, 64'(100 + nresp));
                nresp++;
            end
        end
        chk("stream_count", 64'(nresp), 64'd10);
        chk("stream_b2b_first4", 64'(acc3), 64'd4);
        tick(); tick();

        // Backpressure: only four requests accepted while resp_ready is low.
        resp_ready_i = 1'b0; nacc = 0;
        for (int k = 0; k < 8; k++) begin
            set_req(1'b1, 16'd1, 16'd3, 6'(20 + nacc), 32'(nacc), 32'hF0);
            acc = req_ready_o;
            tick();
            if (acc) nacc++;
        end
        req_valid_i = 1'b0;
        chk("bp_accepted", 64'(nacc), 64'd4);
        chk("bp_ready_low", {63'd0, req_ready_o}, 64'd0);
        chk("bp_credits0", {61'd0, credits_o}, 64'd0);
        tick(); tick();
        chk("bp_head_id", {58'd0, resp_id_o}, 64'd20);
        chk("bp_head_data", {32'd0, resp_data_o}, 64'hF0);
        chk("bp_ready_still_low", {63'd0, req_ready_o}, 64'd0);
        resp_ready_i = 1'b1;
        tick();
        chk("bp_ready_after_pop", {63'd0, req_ready_o}, 64'd1);
        chk("bp_credits1", {61'd0, credits_o}, 64'd1);
        for (int k = 1; k < 4; k++) begin
            chk("bp_order_id", {58'd0, resp_id_o}, 64'(20 + k));
            chk("bp_order_data", {32'd0, resp_data_o}, 64'(32'hF0 ^ k));
            tick();
        end
        chk("bp_drained", {63'd0, resp_valid_o}, 64'd0);
        chk("bp_credits4", {61'd0, credits_o}, 64'd4);

        // Error responses; interface mismatch wins over bad function.
        issue(16'd2, 16'd0, 6'd40, 32'd3, 32'd4);
        expect_resp("err_iid", 6'd40, 32'd0, 1'b0, 32'd1);
        issue(16'd1, 16'd9, 6'd41, 32'd3, 32'd4);
        expect_resp("err_fn", 6'd41, 32'd0, 1'b0, 32'd2);
        issue(16'd2, 16'd9, 6'd42, 32'd3, 32'd4);
        expect_resp("err_both", 6'd42, 32'd0, 1'b0, 32'd1);

        // clock_en low freezes two in-flight wrap-around requests.
        set_req(1'b1, 16'd1, 16'd1, 6'd1, 32'hFFFF_FFFF, 32'd1);
        tick();
        set_req(1'b1, 16'd1, 16'd2, 6'd2, 32'd0, 32'd1);
        tick();
        clock_en_i = 1'b0;
        set_req(1'b1, 16'd1, 16'd3, 6'd3, 32'd5, 32'd5);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("ce_hold_valid", {63'd0, resp_valid_o}, 64'd0);
            chk("ce_hold_credits", {61'd0, credits_o}, 64'd2);
        end
        clock_en_i = 1'b1; req_valid_i = 1'b0;
        tick();
        chk("ce_not_yet", {63'd0, resp_valid_o}, 64'd0);
        tick();
        chk("ce_add_valid", {63'd0, resp_valid_o}, 64'd1);
        chk("ce_add_id", {58'd0, resp_id_o}, 64'd1);
        chk("ce_add_wrap", {32'd0, resp_data_o}, 64'd0);
        chk("ce_add_ok", {63'd0, resp_ok_o}, 64'd1);
        clock_en_i = 1'b0;
        tick();
        chk("ce_nopop_id", {58'd0, resp_id_o}, 64'd1);
        chk("ce_nopop_credits", {61'd0, credits_o}, 64'd2);
        clock_en_i = 1'b1;
        tick();
        chk("ce_sub_id", {58'd0, resp_id_o}, 64'd2);
        chk("ce_sub_wrap", {32'd0, resp_data_o}, 64'hFFFF_FFFF);
        chk("ce_credits3", {61'd0, credits_o}, 64'd3);
        tick();
        chk("ce_drained", {63'd0, resp_valid_o}, 64'd0);
        chk("ce_credits4", {61'd0, credits_o}, 64'd4);

        // Reset with three in the pipeline and one queued; clock_en low
        // during reset checks reset priority.
        resp_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(1'b1, 16'd1, 16'd0, 6'(30 + k), 32'(k), 32'd2);
            tick();
        end
        req_valid_i = 1'b0;
        chk("mrst_pre_valid", {63'd0, resp_valid_o}, 64'd1);
        reset = 1'b1; clock_en_i = 1'b0;
        tick();
        chk("mrst_valid", {63'd0, resp_valid_o}, 64'd0);
        chk("mrst_credits", {61'd0, credits_o}, 64'd4);
        chk("mrst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("mrst_id", {58'd0, resp_id_o}, 64'd0);
        chk("mrst_data", {32'd0, resp_data_o}, 64'd0);
        reset = 1'b0; clock_en_i = 1'b1; resp_ready_i = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (resp_valid_o) stale++;
        end
        chk("mrst_no_stale", 64'(stale), 64'd0);
        chk("mrst_credits_after", {61'd0, credits_o}, 64'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
